// File: rtl/bus_matrix.sv
// Two-master, NUM_SLAVES-slave bus matrix with round-robin ownership and base/mask decode; BUS_DECERR_EN adds m_err and a DEADBEEF read pattern on unmapped accesses.
// Latency: grant one cycle after req; slave-side signals combinational from owner; read data one cycle after the access.
// Backpressure: none on the slave side; a master waits for its grant and is never preempted while it holds req.
module bus_matrix #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] S_BASE = {16'h8000, 16'h7200, 16'h7000, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] S_MASK = {16'hF000, 16'hFE00, 16'hFE00, 16'hF800}
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         m0_req,
  input  logic                         m0_wr,
  input  logic [ADDR_W-1:0]            m0_addr,
  input  logic [DATA_W-1:0]            m0_dout,
  output logic                         m0_grant,
  input  logic                         m1_req,
  input  logic                         m1_wr,
  input  logic [ADDR_W-1:0]            m1_addr,
  input  logic [DATA_W-1:0]            m1_dout,
  output logic                         m1_grant,
  output logic [DATA_W-1:0]            m_din,
`ifdef BUS_DECERR_EN
  output logic                         m_err,
`endif
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_wr,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_din,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dout
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;   // 0: master 0 owned last, 1: master 1
  logic               own_req, own_wr;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_dout;
  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               rd_hit_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic [DATA_W-1:0]  rd_dat;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || last_q)) state_d = OWN0;
        else if (m1_req)                   state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          last_d  = 1'b0;
          state_d = m1_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          last_d  = 1'b1;
          state_d = m0_req ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign m0_grant = (state_q == OWN0);
  assign m1_grant = (state_q == OWN1);

  always_comb begin
    own_req  = 1'b0;
    own_wr   = 1'b0;
    own_addr = '0;
    own_dout = '0;
    if (state_q == OWN0) begin
      own_req  = m0_req;
      own_wr   = m0_wr;
      own_addr = m0_addr;
      own_dout = m0_dout;
    end else if (state_q == OWN1) begin
      own_req  = m1_req;
      own_wr   = m1_wr;
      own_addr = m1_addr;
      own_dout = m1_dout;
    end
  end

  // Descending scan so the lowest matching window is the one that sticks.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((own_addr & S_MASK[i*ADDR_W +: ADDR_W]) == S_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    s_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_sel[i] = own_req && dec_hit && (dec_idx == IDX_W'(i));
    end
  end

  assign s_wr   = own_wr;
  assign s_addr = own_addr;
  assign s_din  = own_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_hit_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_hit_q <= own_req && !own_wr && dec_hit;
      if (own_req && !own_wr) rd_idx_q <= dec_idx;
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (rd_idx_q == IDX_W'(i)) rd_dat = s_dout[i*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_DECERR_EN
  logic err_q, rd_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      err_q    <= own_req && !dec_hit;
      rd_err_q <= own_req && !own_wr && !dec_hit;
    end
  end

  assign m_err = err_q;
  assign m_din = rd_hit_q ? rd_dat : (rd_err_q ? DATA_W'(32'hDEADBEEF) : '0);
`else
  assign m_din = rd_hit_q ? rd_dat : '0;
`endif

endmodule

// File: tb/tb_bus_matrix.sv
// Directed bench for bus_matrix: arbitration, decode, read return and async reset, with a simple slave model.
module tb_bus_matrix;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_addr, m1_addr;
  logic [63:0] m0_dout, m1_dout;
  logic        m0_grant, m1_grant;
  logic [63:0] m_din;
  logic [3:0]  s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [255:0] s_dout;
`ifdef BUS_DECERR_EN
  logic        m_err;
`endif

  localparam logic [63:0] S0_VAL = 64'h1122334455667788;
  localparam logic [63:0] S2_VAL = 64'h2222333344445555;
  localparam logic [63:0] S3_VAL = 64'h3333AAAABBBBCCCC;
  logic [63:0] s1_mem = 64'h0000000000005151;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Slave 1 is a writable register that echoes its contents on reads.
  always @(posedge clk) if (s_sel[1] && s_wr) s1_mem <= s_din;
  assign s_dout = {S3_VAL, S2_VAL, s1_mem, S0_VAL};

  bus_matrix dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_grant(m0_grant),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_grant(m1_grant),
    .m_din(m_din),
`ifdef BUS_DECERR_EN
    .m_err(m_err),
`endif
    .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_dout = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_dout = '0;
    #12;
    chk("rst_m0_grant", 64'(m0_grant), 64'd0);
    chk("rst_m1_grant", 64'(m1_grant), 64'd0);
    chk("rst_s_sel",    64'(s_sel),    64'd0);
    chk("rst_m_din",    m_din,         64'd0);
    #10 reset_n = 1'b1;
    tick();

    // m0 single read of RAM
    m0_req = 1; m0_addr = 16'h0008;
    #1 chk("grant_not_yet", 64'(m0_grant), 64'd0);
    tick();
    chk("m0_grant",  64'(m0_grant), 64'd1);
    chk("rd0_sel",   64'(s_sel),    64'b0001);
    chk("rd0_swr",   64'(s_wr),     64'd0);
    chk("rd0_addr",  64'(s_addr),   64'h0008);
    tick();
    chk("rd0_data",  m_din, S0_VAL);
    m0_req = 0;
    #1 chk("noreq_sel", 64'(s_sel), 64'd0);
    tick();
    chk("idle_m_din",  m_din,          64'd0);
    chk("idle_grant0", 64'(m0_grant),  64'd0);

    // m1 write then read-back of slave 1
    m1_req = 1; m1_wr = 1; m1_addr = 16'h7010; m1_dout = 64'hA5A5;
    tick();
    chk("m1_grant",  64'(m1_grant), 64'd1);
    chk("wr_sel",    64'(s_sel),    64'b0010);
    chk("wr_swr",    64'(s_wr),     64'd1);
    chk("wr_din",    s_din,         64'hA5A5);
    chk("wr_addr",   64'(s_addr),   64'h7010);
    tick();
    m1_wr = 0;
    #1 chk("after_wr_m_din", m_din, 64'd0);
    chk("rdbk_swr", 64'(s_wr), 64'd0);
    tick();
    chk("rdbk_data", m_din, 64'hA5A5);
    m1_req = 0;
    tick();

    // tie after m1 owned: m0 wins, then direct handover to m1
    m0_req = 1; m0_wr = 0; m0_addr = 16'h8000;
    m1_req = 1; m1_wr = 0; m1_addr = 16'h7200;
    tick();
    chk("tie1_m0", 64'(m0_grant), 64'd1);
    chk("tie1_m1", 64'(m1_grant), 64'd0);
    m0_req = 0;
    tick();
    chk("hand_m1", 64'(m1_grant), 64'd1);
    chk("hand_m0", 64'(m0_grant), 64'd0);
    chk("hand_sel", 64'(s_sel), 64'b0100);
    tick();
    chk("hand_rd", m_din, S2_VAL);
    m1_req = 0;
    tick();
    m0_req = 1; m1_req = 1;
    tick();
    chk("tie2_m0", 64'(m0_grant), 64'd1);
    m0_req = 0; m1_req = 0;
    tick();
    m0_req = 1; m1_req = 1;
    tick();
    chk("tie3_m1", 64'(m1_grant), 64'd1);
    chk("tie3_m0", 64'(m0_grant), 64'd0);
    m0_req = 0; m1_req = 0;
    tick();

    // back-to-back reads by m0, then an unmapped read
    m0_req = 1; m0_addr = 16'h0000;
    tick();
    chk("b2b_sel0", 64'(s_sel), 64'b0001);
    tick();
    m0_addr = 16'h7000;
    #1 chk("b2b_dat0", m_din, S0_VAL);
    chk("b2b_sel1", 64'(s_sel), 64'b0010);
    tick();
    m0_addr = 16'h8000;
    #1 chk("b2b_dat1", m_din, 64'hA5A5);
    chk("b2b_sel3", 64'(s_sel), 64'b1000);
    tick();
    m0_addr = 16'hF000;
    #1 chk("b2b_dat3", m_din, S3_VAL);
    chk("unmap_sel", 64'(s_sel), 64'd0);
    tick();
`ifdef BUS_DECERR_EN
    chk("unmap_din", m_din, 64'h00000000DEADBEEF);
    chk("unmap_err", 64'(m_err), 64'd1);
`else
    chk("unmap_din", m_din, 64'd0);
`endif
    m0_req = 0;
    tick();
    chk("post_unmap_din", m_din, 64'd0);
`ifdef BUS_DECERR_EN
    chk("err_pulse_end", 64'(m_err), 64'd0);
`endif

    // async reset during an m1 write
    m1_req = 1; m1_wr = 1; m1_addr = 16'h7010; m1_dout = 64'hBEEF;
    tick();
    chk("pre_rst_swr", 64'(s_wr), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("arst_m1_grant", 64'(m1_grant), 64'd0);
    chk("arst_sel",   64'(s_sel),  64'd0);
    chk("arst_swr",   64'(s_wr),   64'd0);
    chk("arst_m_din", m_din,       64'd0);
    m1_req = 0; m1_wr = 0;
    tick();
    chk("arst_no_write", s1_mem, 64'hA5A5);
    reset_n = 1'b1;
    m0_req = 1; m1_req = 1;
    tick();
    chk("post_rst_tie_m0", 64'(m0_grant), 64'd1);
    chk("post_rst_tie_m1", 64'(m1_grant), 64'd0);
    m0_req = 0; m1_req = 0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
